// File: rtl/social_energy_fsm.sv
// Four-mood social-energy state machine: HAPPY / AWKWARD / VERY_HAPPY / DRAINED,
// driven by a saturating energy counter and a minimum-dwell anti-flicker timer.
module social_energy_fsm #(
  parameter int ENERGY_W       = 6,
  parameter int ENERGY_MAX     = 48,
  parameter int DRAIN_UNKNOWN  = 4,
  parameter int DRAIN_KNOWN    = 1,
  parameter int RECHARGE       = 3,
  parameter int LOW_THRESH     = 8,
  parameter int RECOVER_THRESH = 24,
  parameter int MIN_DWELL      = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                unknown_people,
  input  logic                comfort_zone,
  input  logic                known_people,
  output logic [2:0]          out,
  output logic [ENERGY_W-1:0] energy,
  output logic                drained,
  output logic                state_chg
);

  localparam int DWELL_W = (MIN_DWELL < 2) ? 1 : $clog2(MIN_DWELL + 1);

  typedef enum logic [2:0] {
    HAPPY      = 3'b000,
    AWKWARD    = 3'b001,
    VERY_HAPPY = 3'b010,
    DRAINED    = 3'b011
  } mood_t;

  typedef enum logic [1:0] {
    DOM_NONE,
    DOM_UNKNOWN,
    DOM_KNOWN,
    DOM_COMFORT
  } dom_t;

  mood_t                state;
  mood_t                state_next;
  dom_t                 dom;
  logic [DWELL_W-1:0]   dwell;
  logic [DWELL_W-1:0]   dwell_next;
  logic [ENERGY_W-1:0]  energy_next;
  int                   e_cur;
  int                   e_new;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    dom         = DOM_NONE;
    e_cur       = int'(energy);
    e_new       = e_cur;
    state_next  = state;
    dwell_next  = dwell;

    // Each mood resolves simultaneous inputs with its own priority.
    case (state)
      HAPPY: begin
        if      (known_people)   dom = DOM_KNOWN;
        else if (unknown_people) dom = DOM_UNKNOWN;
        else if (comfort_zone)   dom = DOM_COMFORT;
      end
      AWKWARD: begin
        if      (unknown_people) dom = DOM_UNKNOWN;
        else if (comfort_zone)   dom = DOM_COMFORT;
        else if (known_people)   dom = DOM_KNOWN;
      end
      VERY_HAPPY: begin
        if      (comfort_zone)   dom = DOM_COMFORT;
        else if (known_people)   dom = DOM_KNOWN;
        else if (unknown_people) dom = DOM_UNKNOWN;
      end
      DRAINED: begin
        if (comfort_zone) dom = DOM_COMFORT;
      end
      default: dom = DOM_NONE;
    endcase

    // Saturating energy update; never wraps at either end.
    case (dom)
      DOM_UNKNOWN: e_new = (e_cur > DRAIN_UNKNOWN) ? e_cur - DRAIN_UNKNOWN : 0;
      DOM_KNOWN:   e_new = (e_cur > DRAIN_KNOWN) ? e_cur - DRAIN_KNOWN : 0;
      DOM_COMFORT: e_new = (e_cur + RECHARGE > ENERGY_MAX) ? ENERGY_MAX : e_cur + RECHARGE;
      default:     e_new = e_cur;
    endcase
    energy_next = ENERGY_W'(e_new);

    if (state != HAPPY && state != AWKWARD && state != VERY_HAPPY && state != DRAINED) begin
      state_next = AWKWARD;
    end else if (state != DRAINED && e_cur <= LOW_THRESH) begin
      state_next = DRAINED;
    end else if (state == DRAINED) begin
      if (e_cur >= RECOVER_THRESH) state_next = VERY_HAPPY;
    end else if (dwell == DWELL_W'(MIN_DWELL)) begin
      case (dom)
        DOM_KNOWN:   state_next = HAPPY;
        DOM_UNKNOWN: state_next = AWKWARD;
        DOM_COMFORT: state_next = VERY_HAPPY;
        default:     state_next = state;
      endcase
    end

    if (state_next != state)                 dwell_next = '0;
    else if (dwell != DWELL_W'(MIN_DWELL))   dwell_next = dwell + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  // out/drained are registered from the next state so they always mirror the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= AWKWARD;
      energy    <= ENERGY_W'(ENERGY_MAX);
      dwell     <= '0;
      state_chg <= 1'b0;
      out       <= AWKWARD;
      drained   <= 1'b0;
    end else begin
      state     <= state_next;
      energy    <= energy_next;
      dwell     <= dwell_next;
      state_chg <= (state_next != state);
      out       <= state_next;
      drained   <= (state_next == DRAINED);
    end
  end

endmodule

// File: tb/tb_social_energy_fsm.sv
// Directed bench for social_energy_fsm: a behavioural mood model feeds a scoreboard
// queue, plus constant checkpoints at the interesting edges.
module tb_social_energy_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       unknown_people;
  logic       comfort_zone;
  logic       known_people;
  logic [2:0] out;
  logic [5:0] energy;
  logic       drained;
  logic       state_chg;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [2:0] out;
    logic [5:0] energy;
    logic       drained;
    logic       state_chg;
  } exp_t;

  exp_t sb[$];

  // Behavioural model state
  int ms, me, md, mc;

  social_energy_fsm dut (
    .clk            (clk),
    .reset          (reset),
    .unknown_people (unknown_people),
    .comfort_zone   (comfort_zone),
    .known_people   (known_people),
    .out            (out),
    .energy         (energy),
    .drained        (drained),
    .state_chg      (state_chg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic u, input logic c, input logic k);
    int dom, ne, ns;
    if (r) begin
      ms = 1; me = 48; md = 0; mc = 0;
      return;
    end
    dom = 0;
    case (ms)
      0: dom = k ? 2 : u ? 1 : c ? 3 : 0;
      1: dom = u ? 1 : c ? 3 : k ? 2 : 0;
      2: dom = c ? 3 : k ? 2 : u ? 1 : 0;
      default: dom = c ? 3 : 0;
    endcase
    case (dom)
      1: ne = (me - 4 < 0) ? 0 : me - 4;
      2: ne = (me - 1 < 0) ? 0 : me - 1;
      3: ne = (me + 3 > 48) ? 48 : me + 3;
      default: ne = me;
    endcase
    if (ms != 3 && me <= 8)             ns = 3;
    else if (ms == 3)                   ns = (me >= 24) ? 2 : 3;
    else if (md == 3 && dom != 0)       ns = (dom == 2) ? 0 : (dom == 1) ? 1 : 2;
    else                                ns = ms;
    mc = (ns != ms) ? 1 : 0;
    md = (ns != ms) ? 0 : (md < 3 ? md + 1 : 3);
    ms = ns;
    me = ne;
  endtask

  // Drive one cycle of stimulus, queue the model's prediction, compare after the edge.
  task automatic step(input logic r, input logic u, input logic c, input logic k, input string tag);
    exp_t e;
    reset = r; unknown_people = u; comfort_zone = c; known_people = k;
    model_step(r, u, c, k);
    e.out = 3'(ms); e.energy = 6'(me); e.drained = (ms == 3); e.state_chg = 1'(mc);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".out"},       32'(out),       32'(e.out));
    check({tag, ".energy"},    32'(energy),    32'(e.energy));
    check({tag, ".drained"},   32'(drained),   32'(e.drained));
    check({tag, ".state_chg"}, 32'(state_chg), 32'(e.state_chg));
  endtask

  initial begin
    reset = 1'b1; unknown_people = 1'b1; comfort_zone = 1'b1; known_people = 1'b1;
    ms = 1; me = 48; md = 0; mc = 0;

    // Reset with every input asserted
    step(1, 1, 1, 1, "rst0");
    step(1, 1, 1, 1, "rst1");
    check("reset_out",    32'(out),       32'd1);
    check("reset_energy", 32'(energy),    32'd48);
    check("reset_drained",32'(drained),   32'd0);
    check("reset_chg",    32'(state_chg), 32'd0);

    // Dwell: known only, change lands on the 4th edge
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 1, "dwell_hold");
      check("dwell_hold_out", 32'(out), 32'd1);
    end
    step(0, 0, 0, 1, "dwell_chg");
    check("dwell_chg_out",    32'(out),       32'd0);
    check("dwell_chg_flag",   32'(state_chg), 32'd1);
    check("dwell_chg_energy", 32'(energy),    32'd44);
    step(0, 0, 0, 1, "dwell_after");
    check("dwell_chg_single", 32'(state_chg), 32'd0);

    // Drain: unknown only from reset
    step(1, 0, 0, 0, "rst2");
    for (int i = 1; i <= 10; i++) step(0, 1, 0, 0, "drain");
    check("drain10_energy", 32'(energy), 32'd8);
    check("drain10_out",    32'(out),    32'd1);
    step(0, 1, 0, 0, "drain11");
    check("drain11_out",     32'(out),     32'd3);
    check("drain11_drained", 32'(drained), 32'd1);
    check("drain11_energy",  32'(energy),  32'd4);
    step(0, 1, 0, 0, "drained_ignore");
    step(0, 1, 0, 1, "drained_ignore2");
    check("drained_hold_energy", 32'(energy), 32'd4);

    // Reset mid-DRAINED with comfort asserted
    step(1, 0, 1, 0, "rst_mid");
    check("rst_mid_out",    32'(out),       32'd1);
    check("rst_mid_energy", 32'(energy),    32'd48);
    check("rst_mid_chg",    32'(state_chg), 32'd0);
    // Dwell was cleared: the mood change still needs four edges
    for (int i = 1; i <= 3; i++) step(0, 0, 0, 1, "rst_mid_dwell");
    check("rst_mid_dwell_out", 32'(out), 32'd1);
    step(0, 0, 0, 1, "rst_mid_dwell4");
    check("rst_mid_dwell4_out", 32'(out), 32'd0);

    // Back to DRAINED, then recover
    step(1, 0, 0, 0, "rst3");
    for (int i = 1; i <= 11; i++) step(0, 1, 0, 0, "drain_again");
    check("drain_again_out", 32'(out), 32'd3);
    for (int i = 1; i <= 7; i++) step(0, 0, 1, 0, "recharge");
    check("recharge7_energy", 32'(energy), 32'd25);
    check("recharge7_out",    32'(out),    32'd3);
    step(0, 0, 1, 0, "recover");
    check("recover_out",     32'(out),       32'd2);
    check("recover_drained", 32'(drained),   32'd0);
    check("recover_energy",  32'(energy),    32'd28);
    check("recover_chg",     32'(state_chg), 32'd1);

    // Reach energy 47 in VERY_HAPPY, then saturate with all inputs
    step(0, 0, 0, 1, "vh_known");
    step(0, 0, 0, 1, "vh_known");
    check("vh_known_out", 32'(out), 32'd2);
    for (int i = 1; i <= 7; i++) step(0, 0, 1, 0, "vh_charge");
    check("vh_47_energy", 32'(energy), 32'd47);
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 1, 1, "sat_all");
      check("sat_out",    32'(out),    32'd2);
      check("sat_energy", 32'(energy), 32'd48);
    end

    // No input: hold mood and energy
    step(0, 0, 0, 0, "idle");
    step(0, 0, 0, 0, "idle");
    check("idle_out",    32'(out),    32'd2);
    check("idle_energy", 32'(energy), 32'd48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/social_energy_fsm.md
# social_energy_fsm

Parametrised successor to the three-mood introvert state machine. It adds a fourth DRAINED mood driven by a saturating social-energy counter, and a minimum-dwell timer that suppresses mood flicker. It sits between the social-context input decoders and the mood display/logging logic. All mood, energy and flag outputs are derived from registered state.

## Interface
Parameters:
- ENERGY_W, 6, width of the energy counter
- ENERGY_MAX, 48, energy value after reset and the upper saturation limit
- DRAIN_UNKNOWN, 4, energy lost per cycle when the dominant input is unknown_people
- DRAIN_KNOWN, 1, energy lost per cycle when the dominant input is known_people
- RECHARGE, 3, energy gained per cycle when the dominant input is comfort_zone
- LOW_THRESH, 8, energy at or below which the block enters DRAINED
- RECOVER_THRESH, 24, energy at or above which the block leaves DRAINED
- MIN_DWELL, 3, cycles a mood must be held before a normal mood change is allowed
- Legal values: ENERGY_MAX < 2^ENERGY_W; LOW_THRESH < RECOVER_THRESH <= ENERGY_MAX; MIN_DWELL >= 1

Ports:
- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high
- unknown_people  in  1  social context: strangers present
- comfort_zone  in  1  social context: alone / safe place
- known_people  in  1  social context: friends present
- out  out  3  mood code: HAPPY=000, AWKWARD=001, VERY_HAPPY=010, DRAINED=011
- energy  out  ENERGY_W  current social-energy value
- drained  out  1  high while the state is DRAINED
- state_chg  out  1  high for exactly the first cycle spent in a new state

## Operation
- **Reset values.** State=AWKWARD, energy=ENERGY_MAX, dwell=0, state_chg=0. Therefore out=001 and drained=0.
- **Dominant input.** Selected from inputs sampled at the edge, by a per-state priority:
  - HAPPY: known > unknown > comfort
  - AWKWARD: unknown > comfort > known
  - VERY_HAPPY: comfort > known > unknown
  - DRAINED: comfort only; unknown and known are ignored
  - If no input is asserted there is no dominant input.
- **Energy update.** Uses the dominant input and the current state.
  - unknown: energy − DRAIN_UNKNOWN
  - known: energy − DRAIN_KNOWN
  - comfort: energy + RECHARGE
  - No dominant input, or DRAINED with unknown/known asserted: energy is held.
  - The result saturates at 0 and at ENERGY_MAX. Never wrap.
- **Dwell counter.**
  - Increments each cycle and saturates at MIN_DWELL.
  - Cleared to 0 on every state change.
- **Next-state rules.** Evaluated on current registered values, highest precedence first:
  1. Not DRAINED and energy <= LOW_THRESH: go to DRAINED. Dwell is ignored.
  2. DRAINED and energy >= RECOVER_THRESH: go to VERY_HAPPY. Dwell is ignored.
  3. DRAINED otherwise: hold.
  4. Normal moods, dwell == MIN_DWELL and a dominant input exists: go to the mood mapped to that input (known→HAPPY, unknown→AWKWARD, comfort→VERY_HAPPY).
  5. Otherwise: hold. No input means hold, never a default mood.
- **Outputs.**
  - out and drained are Moore decodes of the state register.
  - state_chg is registered: set on any edge where the next state differs from the current state, cleared otherwise.
- **Illegal state.** Codes 1xx recover to AWKWARD on the next edge, with dwell cleared.

## Timing
- Inputs are sampled on the rising edge. State, energy, dwell and state_chg all update on that same edge.
- Threshold checks use the pre-edge energy. An energy crossing therefore changes state one edge later.
- Energy for an edge is computed from the pre-edge state. On the edge that enters DRAINED, that edge's drain still applies.
- A normal mood change occurs on the (MIN_DWELL+1)-th edge after entering the current mood, given a constant dominant input.
- Reset wins over all activity, including mid-DRAINED, at saturation, or with all inputs asserted. One reset edge restores all reset values.

## Test plan
- **Reset.** Assert reset for 2 cycles with all inputs high → out=001, energy=48, drained=0, state_chg=0.
- **Dwell.** After reset, hold known_people=1 only → out stays 001 for edges 1–3. Edge 4 gives out=000, state_chg=1 for one cycle, energy=44.
- **Drain.** After reset, hold unknown_people=1 only → after 10 edges energy=8 and out=001. Edge 11 gives out=011, drained=1, energy=4. Further unknown edges hold energy at 4.
- **Recovery.** From DRAINED with energy=4, hold comfort_zone=1 → energy steps 7, 10, … and reaches 25 on edge 7. Edge 8 gives out=010, drained=0, energy=28, state_chg=1.
- **Simultaneous inputs and saturation.** In VERY_HAPPY with energy=47, assert all three inputs for 3 edges → state stays 010 and energy=48 on every edge (no wrap).
- **Reset mid-operation.** In DRAINED with energy=4 and comfort_zone=1, pulse reset for 1 edge → out=001, energy=48, dwell=0, state_chg=0 on the next cycle.
